// File: rtl/usrt_pkg.sv
// Shared encodings for the USRT receiver: parity modes, FSM states,
// frame width and the parity reduction used by rxparity.
package usrt_pkg;

  localparam int FRAME_W = 11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  // Data bits plus parity bit; start and stop bits do not take part in parity.
  localparam logic [FRAME_W-1:0] PAR_MASK = 11'b011_1111_1110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_CHECK  = 3'd4
  } rx_state_e;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic frame_parity(input logic [FRAME_W-1:0] frame);
    return ^(frame & PAR_MASK);
  endfunction

endpackage

// File: rtl/rxparity.sv
// Registered parity checker for one assembled receive frame.
// o_ParityOK reflects the frame presented on the previous clock.
module rxparity
  import usrt_pkg::*;
(
  input  logic               i_Pclk,
  input  logic               i_Rst_n,
  input  logic [FRAME_W-1:0] i_Frame,
  input  logic               i_Odd,
  output logic               o_ParityOK
);

  logic ok_r;

  // Even mode: data+parity ones count must be even; odd mode: odd.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ok_r <= 1'b0;
    end else begin
      ok_r <= (frame_parity(i_Frame) == i_Odd);
    end
  end

  assign o_ParityOK = ok_r;

endmodule

// File: rtl/usrt_rx_ctrl_chk.sv
// Interface checker for usrt_rx_ctrl: held byte stability and overrun
// only ever accompanying a held byte.
module usrt_rx_ctrl_chk (
  input logic       i_Pclk,
  input logic       i_Rst_n,
  input logic       i_Ready,
  input logic [7:0] o_Data,
  input logic       o_Valid,
  input logic       o_ParityErr,
  input logic       o_FrameErr,
  input logic       o_Overrun
);

  a_hold_stable: assert property (@(posedge i_Pclk) disable iff (!i_Rst_n)
    (o_Valid && !i_Ready) |=> (o_Valid && $stable(o_Data) &&
                               $stable(o_ParityErr) && $stable(o_FrameErr)));

  a_ovr_needs_valid: assert property (@(posedge i_Pclk) disable iff (!i_Rst_n)
    o_Overrun |-> o_Valid);

endmodule

// File: rtl/usrt_rx_ctrl.sv
// Synchronous serial receiver: start/8 data/optional parity/stop framing,
// one-byte holding register with valid/ready handshake and overrun flag.
// Optional break indication enabled by macro USRT_RX_BREAK_DETECT_EN.
module usrt_rx_ctrl
  import usrt_pkg::*;
#(
  parameter int P_DATA_BITS = 8
)
(
  input  logic       i_Pclk,
  input  logic       i_Rst_n,
  input  logic       i_En,
  input  logic       i_Rx,
  input  logic [1:0] i_Parity,
  input  logic       i_Ready,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_ParityErr,
  output logic       o_FrameErr,
  output logic       o_Overrun,
`ifdef USRT_RX_BREAK_DETECT_EN
  output logic       o_Break,
`endif
  output logic       o_Busy
);

  localparam logic [2:0] LAST_BIT = 3'(P_DATA_BITS - 1);

  rx_state_e          state_r, state_n;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         shift_r;
  logic               par_bit_r;
  logic               stop_r;
  logic [1:0]         mode_r;
  logic [7:0]         data_r;
  logic               valid_r;
  logic               perr_r;
  logic               ferr_r;
  logic               ovr_r;
  logic               busy_r;

  logic               start_s;
  logic               deliver_s;
  logic               par_ok_s;
  logic               perr_s;
  logic               ferr_s;
  logic               odd_s;
  logic [FRAME_W-1:0] frame_s;

  // CHECK doubles as an idle slot so a start bit there chains frames.
  assign start_s   = i_En && !i_Rx && ((state_r == ST_IDLE) || (state_r == ST_CHECK));
  assign deliver_s = (state_r == ST_CHECK);
  assign frame_s   = {stop_r, par_bit_r, shift_r, 1'b0};
  assign odd_s     = (mode_r == PAR_ODD);
  assign perr_s    = parity_enabled(mode_r) ? !par_ok_s : 1'b0;
  assign ferr_s    = !stop_r;

  rxparity u_rxparity (
    .i_Pclk     (i_Pclk),
    .i_Rst_n    (i_Rst_n),
    .i_Frame    (frame_s),
    .i_Odd      (odd_s),
    .o_ParityOK (par_ok_s)
  );

  // FSM state register.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != ST_IDLE);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state_r;
    if (!i_En) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!i_Rx) begin
            state_n = ST_DATA;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (bit_cnt_r == LAST_BIT) begin
            state_n = parity_enabled(mode_r) ? ST_PARITY : ST_STOP;
          end else begin
            state_n = ST_DATA;
          end
        end
        ST_PARITY: state_n = ST_STOP;
        ST_STOP:   state_n = ST_CHECK;
        ST_CHECK: begin
          if (!i_Rx) begin
            state_n = ST_DATA;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  // Frame capture: latch mode at start, shift data LSB-first, grab parity/stop.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_bit_r <= 1'b0;
      stop_r    <= 1'b0;
      mode_r    <= PAR_NONE;
    end else if (!i_En) begin
      bit_cnt_r <= 3'd0;
    end else if (start_s) begin
      mode_r    <= i_Parity;
      bit_cnt_r <= 3'd0;
      par_bit_r <= 1'b0;
    end else if (state_r == ST_DATA) begin
      shift_r   <= {i_Rx, shift_r[7:1]};
      bit_cnt_r <= bit_cnt_r + 3'd1;
    end else if (state_r == ST_PARITY) begin
      par_bit_r <= i_Rx;
    end else if (state_r == ST_STOP) begin
      stop_r    <= i_Rx;
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Holding register: a full register drops the new byte and flags overrun.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else if (deliver_s && valid_r && !i_Ready) begin
      ovr_r   <= 1'b1;
    end else if (deliver_s) begin
      data_r  <= shift_r;
      valid_r <= 1'b1;
      perr_r  <= perr_s;
      ferr_r  <= ferr_s;
      if (valid_r && i_Ready) begin
        ovr_r <= 1'b0;
      end
    end else if (valid_r && i_Ready) begin
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef USRT_RX_BREAK_DETECT_EN
  logic break_r;

  // Break: all-zero data with a zero stop bit, pulsed alongside delivery.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      break_r <= 1'b0;
    end else begin
      break_r <= deliver_s && (shift_r == 8'h00) && !stop_r;
    end
  end

  assign o_Break = break_r;
`endif

  assign o_Data      = data_r;
  assign o_Valid     = valid_r;
  assign o_ParityErr = perr_r;
  assign o_FrameErr  = ferr_r;
  assign o_Overrun   = ovr_r;
  assign o_Busy      = busy_r;

endmodule
